// File: rtl/alu32_checker_pkg.sv
// Shared opcode encodings, FSM states and result type for the alu32 result checker.
// Opcodes must match the encodings alu32 decodes.
package alu32_checker_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] out;
        logic        overflow;
        logic        zero;
        logic        negative;
    } alu_res_t;

    function automatic logic op_known(input logic [2:0] op);
        return op <= ALU_XOR;
    endfunction

    function automatic logic op_has_ovf(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu32_ref.sv
// Combinational golden model of alu32: result plus overflow/zero/negative flags.
module alu32_ref
    import alu32_checker_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  control,
    output alu_res_t    res
);

    always_comb begin
        res = '0;
        case (control)
            ALU_ADD: begin
                res.out      = A + B;
                res.overflow = (A[31] == B[31]) && (res.out[31] != A[31]);
            end
            ALU_SUB: begin
                res.out      = A - B;
                res.overflow = (A[31] != B[31]) && (res.out[31] != A[31]);
            end
            ALU_AND: res.out = A & B;
            ALU_OR:  res.out = A | B;
            ALU_NOR: res.out = ~(A | B);
            ALU_XOR: res.out = A ^ B;
            default: res.out = '0;
        endcase
        res.zero     = (res.out == 32'd0);
        res.negative = res.out[31];
    end

endmodule

// File: rtl/alu32_checker.sv
// Self-check monitor for alu32: recomputes each op, counts checks and mismatches,
// and latches the first failing vector. Two stages: capture+golden, then compare.
module alu32_checker
    import alu32_checker_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter bit          CHECK_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             valid,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    input  logic [2:0]       control,
    input  logic [31:0]      dut_out,
    input  logic             dut_overflow,
    input  logic             dut_zero,
    input  logic             dut_negative,
    output logic             mismatch,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [66:0]      first_fail_op,
    output logic             done,
    output logic             pass
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e      state;
    alu_res_t    exp_res;
    logic        s1_valid;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [2:0]  s1_ctrl;
    alu_res_t    s1_exp;
    alu_res_t    s1_dut;

    logic             s1_fail;
    logic [CNT_W-1:0] check_next;
    logic [CNT_W-1:0] error_next;

    alu32_ref u_ref (
        .A       (A),
        .B       (B),
        .control (control),
        .res     (exp_res)
    );

    always_comb begin
        s1_fail = (s1_exp.out != s1_dut.out) || (s1_exp.zero != s1_dut.zero) ||
                  (s1_exp.negative != s1_dut.negative);
        if (CHECK_OVF && op_has_ovf(s1_ctrl) && (s1_exp.overflow != s1_dut.overflow)) begin
            s1_fail = 1'b1;
        end
        // Unused opcodes are counted but never flagged
        if (!op_known(s1_ctrl)) begin
            s1_fail = 1'b0;
        end
        check_next = check_count;
        error_next = error_count;
        if (s1_valid) begin
            check_next = (check_count == CntMax) ? check_count : check_count + 1'b1;
            if (s1_fail) begin
                error_next = (error_count == CntMax) ? error_count : error_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            s1_valid       <= 1'b0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_ctrl        <= '0;
            s1_exp         <= '0;
            s1_dut         <= '0;
            mismatch       <= 1'b0;
            check_count    <= '0;
            error_count    <= '0;
            first_fail_idx <= '0;
            first_fail_op  <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (start) begin
                // Start wins over stop and drops any op still in flight
                state          <= RUN;
                s1_valid       <= 1'b0;
                check_count    <= '0;
                error_count    <= '0;
                first_fail_idx <= '0;
                first_fail_op  <= '0;
                done           <= 1'b0;
                pass           <= 1'b0;
            end else begin
                check_count <= check_next;
                error_count <= error_next;
                if (s1_valid && s1_fail) begin
                    mismatch <= 1'b1;
                    if (error_count == '0) begin
                        first_fail_idx <= check_count;
                        first_fail_op  <= {s1_ctrl, s1_a, s1_b};
                    end
                end
                s1_valid <= (state == RUN) && valid && !stop;
                if ((state == RUN) && valid && !stop) begin
                    s1_a    <= A;
                    s1_b    <= B;
                    s1_ctrl <= control;
                    s1_exp  <= exp_res;
                    s1_dut  <= '{out: dut_out, overflow: dut_overflow, zero: dut_zero,
                                 negative: dut_negative};
                end
                if ((state == RUN) && stop) begin
                    state <= DONE;
                    done  <= 1'b1;
                    pass  <= (error_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu32_checker.sv
// Directed self-checking bench for alu32_checker, including a 4-bit saturating instance.
module tb_alu32_checker;
    import alu32_checker_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, start2 = 1'b0, stop2 = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] A = '0, B = '0, dut_out = '0;
    logic [2:0]  control = '0;
    logic        dut_overflow = 1'b0, dut_zero = 1'b0, dut_negative = 1'b0;

    logic        mismatch, done, pass;
    logic [15:0] check_count, error_count, first_fail_idx;
    logic [66:0] first_fail_op;

    logic        s_mismatch, s_done, s_pass;
    logic [3:0]  s_check, s_error, s_ffidx;
    logic [66:0] s_ffop;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu32_checker u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
        .A(A), .B(B), .control(control), .dut_out(dut_out),
        .dut_overflow(dut_overflow), .dut_zero(dut_zero), .dut_negative(dut_negative),
        .mismatch(mismatch), .check_count(check_count), .error_count(error_count),
        .first_fail_idx(first_fail_idx), .first_fail_op(first_fail_op),
        .done(done), .pass(pass)
    );

    alu32_checker #(.CNT_W(4), .CHECK_OVF(1'b0)) u_sat (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .valid(valid),
        .A(A), .B(B), .control(control), .dut_out(dut_out),
        .dut_overflow(dut_overflow), .dut_zero(dut_zero), .dut_negative(dut_negative),
        .mismatch(s_mismatch), .check_count(s_check), .error_count(s_error),
        .first_fail_idx(s_ffidx), .first_fail_op(s_ffop),
        .done(s_done), .pass(s_pass)
    );

    // Back-to-back table; entries 3 and 7 carry a corrupted dut_out
    logic [31:0] ta[10] = '{32'd1, 32'd10, 32'hF0F0F0F0, 32'h000000F0, 32'd0,
                            32'hAAAAAAAA, 32'h7FFFFFFF, 32'd5, 32'h12345678, 32'd0};
    logic [31:0] tb[10] = '{32'd1, 32'd3, 32'hFF00FF00, 32'h0000000F, 32'd0,
                            32'h55555555, 32'd1, 32'd5, 32'h12345678, 32'd0};
    logic [2:0]  tc[10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
                            ALU_XOR, ALU_ADD, ALU_SUB, ALU_XOR, 3'b111};
    logic [31:0] to[10] = '{32'd2, 32'd7, 32'hF000F000, 32'h000000FE, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd0, 32'hDEADBEEF};
    logic        tv[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic        tz[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    logic        tn[10] = '{0, 0, 1, 0, 1, 1, 1, 0, 0, 1};
    logic        tm[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

    logic [66:0] exp_op;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] o, input logic v, input logic z, input logic n);
        A = a; B = b; control = c; dut_out = o;
        dut_overflow = v; dut_zero = z; dut_negative = n;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic [31:0] o, input logic v, input logic z, input logic n);
        drive(a, b, c, o, v, z, n);
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_mismatch", mismatch, 0);
        chk("rst_check", check_count, 0);
        chk("rst_error", error_count, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: simple ADD passes
        start = 1'b1; tick(); start = 1'b0;
        send(32'd8, 32'd4, ALU_ADD, 32'd12, 0, 0, 0);
        tick();
        chk("add_mismatch", mismatch, 0);
        chk("add_check", check_count, 1);

        // 2: SUB pass, then wrong negative flag
        send(32'd2, 32'd5, ALU_SUB, 32'hFFFFFFFD, 0, 0, 1);
        tick();
        chk("sub_mismatch", mismatch, 0);
        chk("sub_check", check_count, 2);
        send(32'd2, 32'd5, ALU_SUB, 32'hFFFFFFFD, 0, 0, 0);
        tick();
        chk("subneg_mismatch", mismatch, 1);
        chk("subneg_error", error_count, 1);
        chk("subneg_ffidx", first_fail_idx, 2);
        exp_op = {ALU_SUB, 32'd2, 32'd5};
        chk("subneg_ffop", first_fail_op, exp_op);
        tick();
        chk("pulse_width", mismatch, 0);

        // 3: overflow cases
        send(32'h80000000, 32'h80000000, ALU_ADD, 32'd0, 1, 1, 0);
        tick();
        chk("ovf_neg_mismatch", mismatch, 0);
        send(32'h40000000, 32'h40000000, ALU_ADD, 32'h80000000, 1, 0, 1);
        tick();
        chk("ovf_pos_mismatch", mismatch, 0);
        send(32'h40000000, 32'h40000000, ALU_ADD, 32'h80000000, 0, 0, 1);
        tick();
        chk("ovf_miss_mismatch", mismatch, 1);
        chk("ovf_miss_error", error_count, 2);
        chk("ovf_miss_check", check_count, 6);
        chk("ffidx_kept", first_fail_idx, 2);

        // 4: restart, ten back-to-back ops
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_check", check_count, 0);
        chk("restart_error", error_count, 0);
        for (int i = 0; i < 10; i++) begin
            drive(ta[i], tb[i], tc[i], to[i], tv[i], tz[i], tn[i]);
            valid = 1'b1;
            tick();
            if (i > 0) chk("b2b_mismatch", mismatch, tm[i-1]);
        end
        valid = 1'b0;
        tick();
        chk("b2b_last_mismatch", mismatch, tm[9]);
        chk("b2b_check", check_count, 10);
        chk("b2b_error", error_count, 2);
        chk("b2b_ffidx", first_fail_idx, 3);
        exp_op = {ALU_OR, 32'h000000F0, 32'h0000000F};
        chk("b2b_ffop", first_fail_op, exp_op);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("b2b_done", done, 1);
        chk("b2b_pass", pass, 0);

        // 5: async reset mid-RUN with an op in flight
        start = 1'b1; tick(); start = 1'b0;
        send(32'd1, 32'd1, ALU_ADD, 32'd5, 0, 0, 0);
        drive(32'd3, 32'd3, ALU_ADD, 32'd9, 0, 0, 0);
        valid = 1'b1;
        tick();
        chk("pre_rst_error", error_count, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_mismatch", mismatch, 0);
        chk("arst_check", check_count, 0);
        chk("arst_error", error_count, 0);
        chk("arst_ffop", first_fail_op, 0);
        chk("arst_done", done, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_mismatch", mismatch, 0);
        tick();
        chk("post_rst_mismatch2", mismatch, 0);
        chk("post_rst_check", check_count, 0);
        valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        drive(32'd0, 32'd0, ALU_ADD, 32'd0, 0, 1, 0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        chk("inflight_check", check_count, 1);
        chk("final_done", done, 1);
        chk("final_pass", pass, 1);
        send(32'd1, 32'd1, ALU_ADD, 32'd7, 0, 0, 0);
        tick();
        chk("done_ignore_check", check_count, 1);
        chk("done_ignore_mismatch", mismatch, 0);

        // 6: CHECK_OVF=0 and saturation at CNT_W=4
        start2 = 1'b1; tick(); start2 = 1'b0;
        send(32'h7FFFFFFF, 32'd1, ALU_ADD, 32'h80000000, 0, 0, 1);
        tick();
        chk("noovf_mismatch", s_mismatch, 0);
        chk("noovf_error", s_error, 0);
        chk("noovf_check", s_check, 1);
        drive(32'd1, 32'd1, ALU_ADD, 32'd3, 0, 0, 0);
        valid = 1'b1;
        repeat (20) tick();
        valid = 1'b0;
        tick();
        chk("sat_check", s_check, 15);
        chk("sat_error", s_error, 15);
        chk("sat_ffidx", s_ffidx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
